// File: rtl/iic_slave_regs.sv
// I2C target with a byte register bank: address match, register pointer, then auto-incrementing
// writes or reads. SCL/SDA are oversampled on clk_i; SDA is driven open-drain via sda_oe_o.
//   state     | meaning
//   IDLE      | wait for START       ADDR/PTR/WDATA | shift a byte in     *_ACK | hold ACK low
//   RDATA     | shift a byte out     RACK           | master ACK/NACK     WAIT_STOP | ignore bus
module iic_slave_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         NREG     = 16,
    parameter int         AW       = 4
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe_o,
    output logic              wr_pulse_o,
    output logic [AW-1:0]     wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic [NREG*8-1:0] regs_o,
    output logic              busy_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_WAIT_STOP
    } state_t;

    // [0] first sync stage, [1] synchronized value, [2] previous synchronized value
    logic [2:0] scl_q, sda_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl_i};
            sda_q <= {sda_q[1:0], sda_i};
        end
    end

    logic scl_rise, scl_fall, bus_start, bus_stop, sda_s;
    assign sda_s     = sda_q[1];
    assign scl_rise  =  scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] &  scl_q[2];
    assign bus_start =  scl_q[1] &  scl_q[2] &  sda_q[2] & ~sda_q[1];
    assign bus_stop  =  scl_q[1] &  scl_q[2] & ~sda_q[2] &  sda_q[1];

    state_t          state_q;
    logic [2:0]      bcnt_q;
    logic            done_q;
    logic            rw_q;
    logic            nack_q;
    logic [7:0]      shreg_q;
    logic [AW-1:0]   ptr_q;
    logic [7:0]      regs_q [NREG];
    logic [7:0]      rd_byte;

    assign rd_byte = regs_q[ptr_q];

    for (genvar k = 0; k < NREG; k++) begin : g_flat
        assign regs_o[k*8 +: 8] = regs_q[k];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            bcnt_q     <= 3'd7;
            done_q     <= 1'b0;
            rw_q       <= 1'b0;
            nack_q     <= 1'b0;
            shreg_q    <= '0;
            ptr_q      <= '0;
            sda_oe_o   <= 1'b0;
            wr_pulse_o <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
            busy_o     <= 1'b0;
            for (int k = 0; k < NREG; k++) regs_q[k] <= '0;
        end else begin
            wr_pulse_o <= 1'b0;
            if (bus_start) begin
                state_q  <= S_ADDR;
                bcnt_q   <= 3'd7;
                done_q   <= 1'b0;
                sda_oe_o <= 1'b0;
                busy_o   <= 1'b0;
            end else if (bus_stop) begin
                state_q  <= S_IDLE;
                sda_oe_o <= 1'b0;
                busy_o   <= 1'b0;
            end else begin
                case (state_q)
                    S_ADDR, S_PTR, S_WDATA: begin
                        if (scl_rise && !done_q) begin
                            shreg_q <= {shreg_q[6:0], sda_s};
                            if (bcnt_q == 3'd0) done_q <= 1'b1;
                            else                bcnt_q <= bcnt_q - 3'd1;
                        end else if (scl_fall && done_q) begin
                            done_q <= 1'b0;
                            bcnt_q <= 3'd7;
                            if (state_q == S_ADDR) begin
                                if (shreg_q[7:1] == DEV_ADDR) begin
                                    state_q  <= S_ADDR_ACK;
                                    sda_oe_o <= 1'b1;
                                    busy_o   <= 1'b1;
                                    rw_q     <= shreg_q[0];
                                end else begin
                                    state_q <= S_IDLE;
                                end
                            end else if (state_q == S_PTR) begin
                                state_q  <= S_PTR_ACK;
                                sda_oe_o <= 1'b1;
                                ptr_q    <= shreg_q[AW-1:0];
                            end else begin
                                state_q        <= S_WDATA_ACK;
                                sda_oe_o       <= 1'b1;
                                regs_q[ptr_q]  <= shreg_q;
                                wr_pulse_o     <= 1'b1;
                                wr_addr_o      <= ptr_q;
                                wr_data_o      <= shreg_q;
                                ptr_q          <= ptr_q + AW'(1);
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            bcnt_q <= 3'd7;
                            done_q <= 1'b0;
                            if (rw_q) begin
                                state_q  <= S_RDATA;
                                shreg_q  <= rd_byte;
                                sda_oe_o <= ~rd_byte[7];
                            end else begin
                                state_q  <= S_PTR;
                                sda_oe_o <= 1'b0;
                            end
                        end
                    end
                    S_PTR_ACK, S_WDATA_ACK: begin
                        if (scl_fall) begin
                            state_q  <= S_WDATA;
                            sda_oe_o <= 1'b0;
                            bcnt_q   <= 3'd7;
                            done_q   <= 1'b0;
                        end
                    end
                    S_RDATA: begin
                        // bcnt counts bits still to present; the fall after bit 0 hands SDA to the master
                        if (scl_fall) begin
                            if (bcnt_q == 3'd0) begin
                                state_q  <= S_RACK;
                                sda_oe_o <= 1'b0;
                                ptr_q    <= ptr_q + AW'(1);
                            end else begin
                                shreg_q  <= {shreg_q[6:0], 1'b0};
                                sda_oe_o <= ~shreg_q[6];
                                bcnt_q   <= bcnt_q - 3'd1;
                            end
                        end
                    end
                    S_RACK: begin
                        if (scl_rise) begin
                            nack_q <= sda_s;
                        end else if (scl_fall) begin
                            if (nack_q) begin
                                state_q  <= S_WAIT_STOP;
                                sda_oe_o <= 1'b0;
                            end else begin
                                state_q  <= S_RDATA;
                                shreg_q  <= rd_byte;
                                sda_oe_o <= ~rd_byte[7];
                                bcnt_q   <= 3'd7;
                            end
                        end
                    end
                    S_WAIT_STOP: sda_oe_o <= 1'b0;
                    default:     sda_oe_o <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iic_slave_regs.sv
// Bit-banged I2C master driving iic_slave_regs; expected writes and read bytes are queued
// from a bench-side register model and compared as the DUT produces them.
module tb_iic_slave_regs;

    localparam int Q = 10;

    logic         clk_i = 1'b0;
    logic         rstn_i;
    logic         scl_m, sda_m;
    logic         sda_bus;
    logic         sda_oe_o, wr_pulse_o, busy_o;
    logic [3:0]   wr_addr_o;
    logic [7:0]   wr_data_o;
    logic [127:0] regs_o;

    assign sda_bus = sda_m & ~sda_oe_o;

    iic_slave_regs dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .scl_i      (scl_m),
        .sda_i      (sda_bus),
        .sda_oe_o   (sda_oe_o),
        .wr_pulse_o (wr_pulse_o),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o),
        .regs_o     (regs_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  mregs [16];
    logic [3:0]  mptr;
    logic [11:0] wr_exp_q [$];
    logic [7:0]  rd_exp_q [$];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] ptr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       ack;
    } vec_t;
    vec_t vec [6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[k*8 +: 8] = mregs[k];
        return r;
    endfunction

    task automatic tick(input int n);
        logic [11:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            if (wr_pulse_o) begin
                if (wr_exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL wr_unexpected: got addr %0d data %h expected no write", wr_addr_o, wr_data_o);
                end else begin
                    e = wr_exp_q.pop_front();
                    check("wr_addr", wr_addr_o, e[11:8]);
                    check("wr_data", wr_data_o, e[7:0]);
                end
            end
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(2*Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        b = sda_bus;  tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        logic [7:0] rptr [2];

        vec[0] = '{8'hA0, 8'h03, 8'h5A, 8'hC3, 1'b1};
        vec[1] = '{8'hA0, 8'h0F, 8'h11, 8'h22, 1'b1};
        vec[2] = '{8'hA0, 8'hF5, 8'h77, 8'h88, 1'b1};
        vec[3] = '{8'hA2, 8'h09, 8'hEE, 8'hDD, 1'b0};
        vec[4] = '{8'h00, 8'h0A, 8'hEE, 8'hDD, 1'b0};
        vec[5] = '{8'hA0, 8'h0A, 8'h01, 8'h80, 1'b1};
        rptr[0] = 8'h03;
        rptr[1] = 8'h0F;
        for (int k = 0; k < 16; k++) mregs[k] = 8'h00;
        mptr = 4'd0;

        rstn_i = 1'b0;
        scl_m  = 1'b1;
        sda_m  = 1'b1;
        tick(5);
        check("rst_sda_oe", sda_oe_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_wr_pulse", wr_pulse_o, 1'b0);
        check("rst_regs", regs_o, 128'h0);
        rstn_i = 1'b1;
        tick(2*Q);
        check("idle_sda_oe", sda_oe_o, 1'b0);

        // Table-driven write transactions: START, addr, pointer, two data bytes, STOP
        for (int v = 0; v < 6; v++) begin
            i2c_start();
            write_byte(vec[v].addr, ack);
            check("addr_ack", ack, vec[v].ack);
            check("busy_after_addr", busy_o, vec[v].ack);
            write_byte(vec[v].ptr, ack);
            check("ptr_ack", ack, vec[v].ack);
            if (vec[v].ack) mptr = vec[v].ptr[3:0];
            for (int j = 0; j < 2; j++) begin
                d = (j == 0) ? vec[v].d0 : vec[v].d1;
                if (vec[v].ack) begin
                    wr_exp_q.push_back({mptr, d});
                    mregs[mptr] = d;
                    mptr = mptr + 4'd1;
                end
                write_byte(d, ack);
                check("data_ack", ack, vec[v].ack);
            end
            i2c_stop();
            tick(Q);
            check("busy_after_stop", busy_o, 1'b0);
            check("regs_after_write", regs_o, model_flat());
            check("wr_pending", wr_exp_q.size(), 0);
        end

        // Reads via repeated START: ACK the first byte, NACK the second
        for (int r = 0; r < 2; r++) begin
            i2c_start();
            write_byte(8'hA0, ack);
            check("rd_addr_w_ack", ack, 1'b1);
            write_byte(rptr[r], ack);
            check("rd_ptr_ack", ack, 1'b1);
            mptr = rptr[r][3:0];
            i2c_start();
            write_byte(8'hA1, ack);
            check("rd_addr_r_ack", ack, 1'b1);
            check("rd_busy", busy_o, 1'b1);
            for (int j = 0; j < 2; j++) begin
                rd_exp_q.push_back(mregs[mptr]);
                mptr = mptr + 4'd1;
                read_byte(d, (j == 1));
                check("rd_data", d, rd_exp_q.pop_front());
            end
            check("rd_released_after_nack", sda_oe_o, 1'b0);
            i2c_stop();
            tick(Q);
            check("rd_sda_oe_after_stop", sda_oe_o, 1'b0);
            check("rd_busy_after_stop", busy_o, 1'b0);
        end

        // STOP after four data bits: no write may happen
        i2c_start();
        write_byte(8'hA0, ack);
        check("abort_addr_ack", ack, 1'b1);
        write_byte(8'h07, ack);
        check("abort_ptr_ack", ack, 1'b1);
        for (int i = 0; i < 4; i++) write_bit(i[0] ? 1'b0 : 1'b1);
        i2c_stop();
        tick(Q);
        check("abort_busy", busy_o, 1'b0);
        check("abort_sda_oe", sda_oe_o, 1'b0);
        check("abort_regs", regs_o, model_flat());

        // Reset while the address ACK is being driven
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(i == 7 || i == 5);
        sda_m = 1'b1;
        tick(Q);
        check("ack_driven", sda_oe_o, 1'b1);
        rstn_i = 1'b0;
        #1;
        check("rst_mid_ack_sda_oe", sda_oe_o, 1'b0);
        check("rst_mid_ack_busy", busy_o, 1'b0);
        check("rst_mid_ack_regs", regs_o, 128'h0);
        for (int k = 0; k < 16; k++) mregs[k] = 8'h00;
        tick(3);
        rstn_i = 1'b1;
        scl_m  = 1'b1;
        tick(2*Q);
        check("post_rst_idle_oe", sda_oe_o, 1'b0);

        i2c_start();
        write_byte(8'hA0, ack);
        check("post_rst_addr_ack", ack, 1'b1);
        write_byte(8'h02, ack);
        mptr = 4'd2;
        wr_exp_q.push_back({mptr, 8'h3C});
        mregs[mptr] = 8'h3C;
        write_byte(8'h3C, ack);
        check("post_rst_data_ack", ack, 1'b1);
        i2c_stop();
        tick(Q);
        check("post_rst_regs", regs_o, model_flat());
        check("final_wr_pending", wr_exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
